// File: rtl/mmu_arb_pkg.sv
// Purpose: shared types and constants for the MMU request front-end (FSM states, owner tags, bad codes).
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package mmu_arb_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    RESP  = 3'd3,
    DRAIN = 3'd4
  } state_e;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_e;

  // rsp_bad / mmu_pa_bad encoding: {bus_err, pg_fault}
  localparam logic [1:0] BAD_PGF = 2'b01;
  localparam logic [1:0] BAD_BUS = 2'b10;

  // Watchdog counter width; never zero so the counter stays a legal vector when the watchdog is disabled.
  function automatic int wdog_width(input int timeout_cyc);
    return (timeout_cyc == 0) ? 1 : $clog2(timeout_cyc + 1);
  endfunction

endpackage

// File: rtl/arb2_rr.sv
// Purpose: two-way IFU/LSU grant with round-robin pointer or fixed LSU priority.
// Latency: combinational grant in the cycle en is high; pointer updates on the following edge.
// Backpressure: no grant while en is low; pointer only moves when a grant is issued.
//
// Ports:
//   clk, rst           clock, async active-high reset
//   req_ifu, req_lsu   eligible requests (already masked by kill)
//   en                 grant window open (IDLE and no TLB flush)
//   gnt_ifu, gnt_lsu   one-hot grant, at most one high
module arb2_rr
  import mmu_arb_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic req_ifu,
  input  logic req_lsu,
  input  logic en,
  output logic gnt_ifu,
  output logic gnt_lsu
);

  owner_e rr_ptr;
  logic   pick_lsu;

  // On a tie the pointer decides (or LSU when round-robin is off); a lone requester always wins.
  always_comb begin
    pick_lsu = req_lsu;
    if (req_ifu && req_lsu) begin
      pick_lsu = RR_EN ? (rr_ptr == OWN_LSU) : 1'b1;
    end
    gnt_ifu = en & req_ifu & ~pick_lsu;
    gnt_lsu = en & req_lsu & pick_lsu;
  end

  // After any grant the pointer favours the side that was not served.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= OWN_IFU;
    end else if (gnt_ifu) begin
      rr_ptr <= OWN_LSU;
    end else if (gnt_lsu) begin
      rr_ptr <= OWN_IFU;
    end
  end

endmodule

// File: rtl/mmu_req_arb.sv
// Purpose: arbitrates IFU/LSU translation requests onto the single mmu port and routes pa/bad back.
// Latency: accept cycle 0, mmu_va_valid cycle 1, rsp_valid one cycle after mmu_pa_valid (or after timeout).
// Backpressure: one request outstanding; *_req_ready only pulses in IDLE without tlb_flush_req.
//
// Ports:
//   clk, rst                          clock, async active-high reset
//   ifu_req_* / lsu_req_*             request valid/va (lsu also w), ready is a one-cycle accept pulse
//   ifu_kill / lsu_kill               requester flush: blocks its grant, drops its outstanding response
//   ifu_rsp_* / lsu_rsp_*             response pulse plus shared registered pa/bad
//   tlb_flush_req                     blocks new grants
//   mmu_va_valid/va/access_w/access_x translation start to mmu
//   mmu_pa_valid/pa/pa_bad            translation result from mmu
//   busy                              state != IDLE
module mmu_req_arb
  import mmu_arb_pkg::*;
#(
  parameter int VA_W        = 48,
  parameter int PA_W        = 56,
  parameter int TIMEOUT_CYC = 1024,
  parameter int RR_EN       = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ifu_req_valid,
  input  logic [VA_W-1:0] ifu_req_va,
  output logic            ifu_req_ready,
  input  logic            ifu_kill,
  output logic            ifu_rsp_valid,
  output logic [PA_W-1:0] ifu_rsp_pa,
  output logic [1:0]      ifu_rsp_bad,
  input  logic            lsu_req_valid,
  input  logic [VA_W-1:0] lsu_req_va,
  input  logic            lsu_req_w,
  output logic            lsu_req_ready,
  input  logic            lsu_kill,
  output logic            lsu_rsp_valid,
  output logic [PA_W-1:0] lsu_rsp_pa,
  output logic [1:0]      lsu_rsp_bad,
  input  logic            tlb_flush_req,
  output logic            mmu_va_valid,
  output logic [VA_W-1:0] mmu_va,
  output logic            mmu_access_w,
  output logic            mmu_access_x,
  input  logic            mmu_pa_valid,
  input  logic [PA_W-1:0] mmu_pa,
  input  logic [1:0]      mmu_pa_bad,
  output logic            busy
);

  localparam int              WD_W    = wdog_width(TIMEOUT_CYC);
  localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT_CYC);
  localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT_CYC == 0) ? '0 : WD_W'(TIMEOUT_CYC - 1);

  state_e          state;
  owner_e          owner;
  logic [VA_W-1:0] va_q;
  logic            w_q;
  logic            x_q;
  logic [PA_W-1:0] pa_q;
  logic [1:0]      bad_q;
  logic            drop;
  logic            late;
  logic [WD_W-1:0] wdog;

  logic gnt_ifu, gnt_lsu;
  logic owner_kill;
  logic timeout_hit;
  logic rsp_fire;

  arb2_rr #(
    .RR_EN (RR_EN != 0)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req_ifu (ifu_req_valid & ~ifu_kill),
    .req_lsu (lsu_req_valid & ~lsu_kill),
    .en      ((state == IDLE) & ~tlb_flush_req),
    .gnt_ifu (gnt_ifu),
    .gnt_lsu (gnt_lsu)
  );

  assign owner_kill  = (owner == OWN_IFU) ? ifu_kill : lsu_kill;
  assign timeout_hit = (TIMEOUT_CYC != 0) && (wdog == WD_LAST);
  // A kill landing in the RESP cycle itself still suppresses the pulse.
  assign rsp_fire    = (state == RESP) & ~drop & ~owner_kill;

  assign ifu_req_ready = gnt_ifu;
  assign lsu_req_ready = gnt_lsu;
  assign ifu_rsp_valid = rsp_fire & (owner == OWN_IFU);
  assign lsu_rsp_valid = rsp_fire & (owner == OWN_LSU);
  assign ifu_rsp_pa    = pa_q;
  assign lsu_rsp_pa    = pa_q;
  assign ifu_rsp_bad   = bad_q;
  assign lsu_rsp_bad   = bad_q;
  assign mmu_va_valid  = (state == ISSUE);
  assign mmu_va        = va_q;
  assign mmu_access_w  = w_q;
  assign mmu_access_x  = x_q;
  assign busy          = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      owner <= OWN_IFU;
      va_q  <= '0;
      w_q   <= 1'b0;
      x_q   <= 1'b0;
      pa_q  <= '0;
      bad_q <= '0;
      drop  <= 1'b0;
      late  <= 1'b0;
      wdog  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_ifu || gnt_lsu) begin
            va_q  <= gnt_lsu ? lsu_req_va : ifu_req_va;
            w_q   <= gnt_lsu & lsu_req_w;
            x_q   <= gnt_ifu;
            owner <= gnt_lsu ? OWN_LSU : OWN_IFU;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          wdog  <= '0;
          if (owner_kill) drop <= 1'b1;
          state <= WAIT;
        end
        WAIT: begin
          if (owner_kill) drop <= 1'b1;
          if (wdog != WD_MAX) wdog <= wdog + WD_W'(1);
          // A real completion in the timeout cycle wins over the forced bus error.
          if (mmu_pa_valid) begin
            pa_q  <= mmu_pa;
            bad_q <= mmu_pa_bad;
            state <= RESP;
          end else if (timeout_hit) begin
            pa_q  <= '0;
            bad_q <= BAD_BUS;
            late  <= 1'b1;
            state <= RESP;
          end
        end
        RESP: begin
          // The mmu still owes a result after a timeout; swallow it in DRAIN.
          if (late) begin
            state <= DRAIN;
          end else begin
            drop  <= 1'b0;
            state <= IDLE;
          end
        end
        DRAIN: begin
          if (mmu_pa_valid) begin
            late  <= 1'b0;
            drop  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mmu_req_arb.sv
// Purpose: self-checking bench for mmu_req_arb: directed scenarios then randomized transactions vs a model.
// Latency: model expects accept c0, mmu_va_valid c1, rsp one cycle after mmu_pa_valid or timeout.
// Backpressure: checks that no request is accepted while a translation is outstanding or flush is high.
module tb_mmu_req_arb;

  localparam int VA_W = 48;
  localparam int PA_W = 56;
  localparam int TO   = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            ifu_req_valid = 1'b0;
  logic [VA_W-1:0] ifu_req_va = '0;
  logic            ifu_req_ready;
  logic            ifu_kill = 1'b0;
  logic            ifu_rsp_valid;
  logic [PA_W-1:0] ifu_rsp_pa;
  logic [1:0]      ifu_rsp_bad;
  logic            lsu_req_valid = 1'b0;
  logic [VA_W-1:0] lsu_req_va = '0;
  logic            lsu_req_w = 1'b0;
  logic            lsu_req_ready;
  logic            lsu_kill = 1'b0;
  logic            lsu_rsp_valid;
  logic [PA_W-1:0] lsu_rsp_pa;
  logic [1:0]      lsu_rsp_bad;
  logic            tlb_flush_req = 1'b0;
  logic            mmu_va_valid;
  logic [VA_W-1:0] mmu_va;
  logic            mmu_access_w;
  logic            mmu_access_x;
  logic            mmu_pa_valid = 1'b0;
  logic [PA_W-1:0] mmu_pa = '0;
  logic [1:0]      mmu_pa_bad = '0;
  logic            busy;

  int n_vec = 0;
  int n_err = 0;

  // Reference state: which side wins the next tie (0=IFU, 1=LSU) and the last delivered pa/bad.
  bit              m_ptr = 1'b0;
  logic [PA_W-1:0] m_pa  = '0;
  logic [1:0]      m_bad = '0;

  always #5 clk = ~clk;

  mmu_req_arb #(
    .VA_W(VA_W), .PA_W(PA_W), .TIMEOUT_CYC(TO), .RR_EN(1)
  ) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_va(ifu_req_va), .ifu_req_ready(ifu_req_ready),
    .ifu_kill(ifu_kill), .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_pa(ifu_rsp_pa), .ifu_rsp_bad(ifu_rsp_bad),
    .lsu_req_valid(lsu_req_valid), .lsu_req_va(lsu_req_va), .lsu_req_w(lsu_req_w),
    .lsu_req_ready(lsu_req_ready), .lsu_kill(lsu_kill), .lsu_rsp_valid(lsu_rsp_valid),
    .lsu_rsp_pa(lsu_rsp_pa), .lsu_rsp_bad(lsu_rsp_bad),
    .tlb_flush_req(tlb_flush_req),
    .mmu_va_valid(mmu_va_valid), .mmu_va(mmu_va), .mmu_access_w(mmu_access_w), .mmu_access_x(mmu_access_x),
    .mmu_pa_valid(mmu_pa_valid), .mmu_pa(mmu_pa), .mmu_pa_bad(mmu_pa_bad),
    .busy(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_hold(input string tag);
    chkw({tag, "_ifu_pa"}, 64'(ifu_rsp_pa), 64'(m_pa));
    chkw({tag, "_lsu_pa"}, 64'(lsu_rsp_pa), 64'(m_pa));
    chkw({tag, "_ifu_bad"}, 64'(ifu_rsp_bad), 64'(m_bad));
    chkw({tag, "_lsu_bad"}, 64'(lsu_rsp_bad), 64'(m_bad));
  endtask

  // One full transaction. d = cycles from mmu_va_valid to mmu_pa_valid (1..TO), 0 = mmu silent.
  // kill_at / nk_at = cycle (relative to accept) of an owner / non-owner kill, 0 = none.
  task automatic txn(input bit iv, input bit lv, input int c0k, input int nflush, input int d,
                     input int kill_at, input int nk_at, input int drain_wait, input int wsel,
                     input logic [PA_W-1:0] pa, input logic [1:0] bad);
    logic [VA_W-1:0] vai, val, exp_va;
    logic [PA_W-1:0] exp_pa;
    logic [1:0]      exp_bad;
    logic            w;
    bit              ei, el, own_l, drop;
    int              rc;
    vai  = {16'($urandom), $urandom};
    val  = {16'($urandom), $urandom};
    w    = (wsel == 2) ? 1'($urandom_range(0, 1)) : (wsel == 1);
    rc   = (d == 0) ? TO + 2 : d + 2;
    drop = 1'b0;
    ifu_req_va = vai; lsu_req_va = val; lsu_req_w = w;
    ifu_req_valid = iv; lsu_req_valid = lv;
    tlb_flush_req = 1'b1;
    for (int i = 0; i < nflush; i++) begin
      settle();
      chk1("flush_ifu_ready", ifu_req_ready, 1'b0);
      chk1("flush_lsu_ready", lsu_req_ready, 1'b0);
      tick();
    end
    tlb_flush_req = 1'b0;
    ifu_kill = (c0k == 1);
    lsu_kill = (c0k == 2);
    ei = iv && (c0k != 1);
    el = lv && (c0k != 2);
    own_l = (ei && el) ? m_ptr : el;
    settle();
    chk1("acc_ifu_ready", ifu_req_ready, ei && !own_l);
    chk1("acc_lsu_ready", lsu_req_ready, own_l);
    m_ptr  = !own_l;
    exp_va = own_l ? val : vai;
    tick();
    ifu_req_valid = 1'($urandom_range(0, 1));
    lsu_req_valid = 1'($urandom_range(0, 1));
    for (int c = 1; c <= rc; c++) begin
      ifu_kill = (c == kill_at && !own_l) || (c == nk_at && own_l);
      lsu_kill = (c == kill_at && own_l) || (c == nk_at && !own_l);
      if (c == kill_at) drop = 1'b1;
      mmu_pa_valid = (d != 0) && (c == d + 1);
      mmu_pa = pa; mmu_pa_bad = bad;
      if (c == rc) begin ifu_req_valid = 1'b0; lsu_req_valid = 1'b0; end
      settle();
      chk1("busy_ifu_ready", ifu_req_ready, 1'b0);
      chk1("busy_lsu_ready", lsu_req_ready, 1'b0);
      chk1("busy", busy, 1'b1);
      chk1("mmu_va_valid", mmu_va_valid, c == 1);
      if (c == 1) begin
        chkw("mmu_va", 64'(mmu_va), 64'(exp_va));
        chk1("mmu_access_w", mmu_access_w, own_l && w);
        chk1("mmu_access_x", mmu_access_x, !own_l);
      end
      if (c < rc) begin
        chk1("early_ifu_rsp", ifu_rsp_valid, 1'b0);
        chk1("early_lsu_rsp", lsu_rsp_valid, 1'b0);
        chk_hold("hold");
      end else begin
        exp_pa  = (d != 0) ? pa : '0;
        exp_bad = (d != 0) ? bad : 2'b10;
        chk1("ifu_rsp_valid", ifu_rsp_valid, !own_l && !drop);
        chk1("lsu_rsp_valid", lsu_rsp_valid, own_l && !drop);
        m_pa = exp_pa; m_bad = exp_bad;
        chk_hold("rsp");
      end
      tick();
    end
    ifu_kill = 1'b0; lsu_kill = 1'b0; mmu_pa_valid = 1'b0;
    if (d == 0) begin
      for (int i = 0; i <= drain_wait; i++) begin
        ifu_req_valid = (i != drain_wait) && 1'($urandom_range(0, 1));
        lsu_req_valid = (i != drain_wait) && 1'($urandom_range(0, 1));
        mmu_pa_valid  = (i == drain_wait);
        mmu_pa        = {24'($urandom), $urandom};
        settle();
        chk1("drain_busy", busy, 1'b1);
        chk1("drain_ifu_ready", ifu_req_ready, 1'b0);
        chk1("drain_lsu_ready", lsu_req_ready, 1'b0);
        chk1("drain_ifu_rsp", ifu_rsp_valid, 1'b0);
        chk1("drain_lsu_rsp", lsu_rsp_valid, 1'b0);
        chk_hold("drain");
        tick();
      end
      mmu_pa_valid = 1'b0;
    end
    // Back in IDLE; a stray mmu result here must be ignored.
    mmu_pa_valid = 1'($urandom_range(0, 1));
    mmu_pa       = {24'($urandom), $urandom};
    settle();
    chk1("idle_busy", busy, 1'b0);
    chk1("idle_ifu_rsp", ifu_rsp_valid, 1'b0);
    chk1("idle_lsu_rsp", lsu_rsp_valid, 1'b0);
    chk1("idle_mmu_va_valid", mmu_va_valid, 1'b0);
    chk_hold("idle");
    tick();
    mmu_pa_valid = 1'b0;
  endtask

  initial begin
    repeat (2) tick();
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_ifu_ready", ifu_req_ready, 1'b0);
    chk1("rst_mmu_va_valid", mmu_va_valid, 1'b0);
    chk1("rst_ifu_rsp", ifu_rsp_valid, 1'b0);
    chk1("rst_lsu_rsp", lsu_rsp_valid, 1'b0);
    chk_hold("rst");
    rst = 1'b0;
    tick();

    // Ties after reset alternate IFU, LSU, IFU.
    txn(1, 1, 0, 0, 2, 0, 0, 0, 2, 56'h1234_5678, 2'b00);
    txn(1, 1, 0, 0, 2, 0, 0, 0, 2, 56'h2000, 2'b00);
    txn(1, 1, 0, 0, 3, 0, 0, 0, 2, 56'h3000, 2'b00);
    // IFU, result three cycles after issue -> rsp at cycle 5.
    txn(1, 0, 0, 0, 3, 0, 0, 0, 0, 56'h8000_1000, 2'b00);
    // LSU store with page fault.
    txn(0, 1, 0, 0, 2, 0, 0, 0, 1, 56'h00ab_cdef, 2'b01);
    // Owner kill in WAIT, in ISSUE and in RESP; non-owner kill has no effect.
    txn(1, 0, 0, 0, 4, 3, 0, 0, 0, 56'h4444, 2'b00);
    txn(0, 1, 0, 0, 3, 1, 0, 0, 0, 56'h5555, 2'b00);
    txn(0, 1, 0, 0, 2, 4, 0, 0, 0, 56'h6666, 2'b00);
    txn(1, 0, 0, 0, 3, 0, 2, 0, 0, 56'h7777, 2'b01);
    // Watchdog: silent mmu -> bus error at cycle 10, drain; result exactly on the timeout cycle wins.
    txn(1, 0, 0, 0, 0, 0, 0, 3, 0, 56'h9999, 2'b00);
    txn(0, 1, 0, 0, TO, 0, 0, 0, 0, 56'haaaa, 2'b01);
    // Flush holds off grants; kill at accept makes the other side win.
    txn(1, 1, 0, 3, 2, 0, 0, 0, 2, 56'hbbbb, 2'b00);
    txn(1, 1, 1, 0, 2, 0, 0, 0, 2, 56'hcccc, 2'b00);
    txn(1, 1, 2, 0, 2, 0, 0, 0, 2, 56'hdddd, 2'b00);

    for (int t = 0; t < 150; t++) begin
      bit iv, lv;
      int c0k, d, rc, ka, nk;
      iv = 1'($urandom_range(0, 1));
      lv = 1'($urandom_range(0, 1));
      if (!iv && !lv) begin
        if ($urandom_range(0, 1) == 0) iv = 1'b1; else lv = 1'b1;
      end
      c0k = 0;
      if (iv && lv && $urandom_range(0, 4) == 0) c0k = int'($urandom_range(1, 2));
      d  = ($urandom_range(0, 6) == 0) ? 0 : int'($urandom_range(1, TO));
      rc = (d == 0) ? TO + 2 : d + 2;
      ka = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, rc)) : 0;
      nk = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, rc)) : 0;
      txn(iv, lv, c0k, int'($urandom_range(0, 2)), d, ka, nk, int'($urandom_range(0, 4)), 2,
          {24'($urandom), $urandom}, 2'($urandom));
    end

    // Reset in the middle of a WAIT; the late mmu result afterwards must be ignored.
    ifu_req_valid = 1'b1; lsu_req_valid = 1'b0;
    settle();
    chk1("mid_acc", ifu_req_ready, 1'b1);
    tick();
    ifu_req_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    settle();
    chk1("mid_rst_busy", busy, 1'b0);
    chk1("mid_rst_va_valid", mmu_va_valid, 1'b0);
    chk1("mid_rst_ifu_rsp", ifu_rsp_valid, 1'b0);
    m_ptr = 1'b0; m_pa = '0; m_bad = '0;
    chk_hold("mid_rst");
    tick();
    rst = 1'b0;
    mmu_pa_valid = 1'b1; mmu_pa = 56'hdead_beef; mmu_pa_bad = 2'b01;
    settle();
    chk1("post_rst_busy", busy, 1'b0);
    chk1("post_rst_ifu_rsp", ifu_rsp_valid, 1'b0);
    tick();
    mmu_pa_valid = 1'b0;
    settle();
    chk1("post_rst_ifu_rsp2", ifu_rsp_valid, 1'b0);
    chk_hold("post_rst");
    txn(1, 1, 0, 0, 2, 0, 0, 0, 2, 56'heeee, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
